// File: rtl/gen_enable_multi.sv
`default_nettype none
// ============================================================================
// Module   : gen_enable_multi
// Brief    : Multi-channel clock-enable generator with shadowed divide/phase
//            configuration and a common synchronous realign.
// Revision : 1.0
// ============================================================================
module gen_enable_multi #(
    parameter int WIDTH         = 5,
    parameter int CHANNELS      = 4,
    parameter int DEFAULT_LIMIT = 24,
    parameter int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [WIDTH-1:0]          cfg_limit,
    input  logic [WIDTH-1:0]          cfg_phase,
    output logic [CHANNELS-1:0]       en_out,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic                      aligned,
    output logic                      cfg_err
);

    localparam logic [WIDTH-1:0] c_default_limit = WIDTH'(DEFAULT_LIMIT);
    localparam logic [CH_W:0]    c_channels      = (CH_W+1)'(CHANNELS);

    logic                w_cfg_valid;
    logic                w_wr_ok;
    logic [CHANNELS-1:0] w_zero;
    logic                r_cfg_err;

    // A write is only legal if the phase is reachable and the channel exists.
    assign w_cfg_valid = ({1'b0, cfg_ch} < c_channels) && (cfg_phase <= cfg_limit);
    assign w_wr_ok     = cfg_we & w_cfg_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we & ~w_cfg_valid;
        end
    end

    assign cfg_err = r_cfg_err;
    assign aligned = &w_zero;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] r_limit;
            logic [WIDTH-1:0] r_phase;
            logic [WIDTH-1:0] r_p_limit;
            logic [WIDTH-1:0] r_p_phase;
            logic             w_sel;
            logic             w_wrap;
            logic             w_load;

            assign w_sel  = w_wr_ok && (cfg_ch == CH_W'(i));
            assign w_wrap = en && (r_cnt == r_limit);
            // Active values only change when the counter is about to be 0,
            // so the counter can never sit above its active limit.
            assign w_load = sync | w_wrap;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt     <= '0;
                    r_limit   <= c_default_limit;
                    r_phase   <= '0;
                    r_p_limit <= c_default_limit;
                    r_p_phase <= '0;
                end else begin
                    if (sync) begin
                        r_cnt <= '0;
                    end else if (en) begin
                        r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
                    end

                    if (w_sel) begin
                        r_p_limit <= cfg_limit;
                        r_p_phase <= cfg_phase;
                    end

                    // Write-through when the write coincides with a load edge.
                    if (w_load) begin
                        r_limit <= w_sel ? cfg_limit : r_p_limit;
                        r_phase <= w_sel ? cfg_phase : r_p_phase;
                    end
                end
            end

            assign en_out[i]                = en & (r_cnt == r_phase);
            assign count[i*WIDTH +: WIDTH]  = r_cnt;
            assign w_zero[i]                = (r_cnt == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gen_enable_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_enable_multi
// Brief    : Directed self-checking bench for gen_enable_multi.
// Revision : 1.0
// ============================================================================
module tb_gen_enable_multi;

    localparam int WIDTH    = 5;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      en;
    logic                      sync;
    logic                      cfg_we;
    logic [CH_W-1:0]           cfg_ch;
    logic [WIDTH-1:0]          cfg_limit;
    logic [WIDTH-1:0]          cfg_phase;
    logic [CHANNELS-1:0]       en_out;
    logic [CHANNELS*WIDTH-1:0] count;
    logic                      aligned;
    logic                      cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    gen_enable_multi #(
        .WIDTH        (WIDTH),
        .CHANNELS     (CHANNELS),
        .DEFAULT_LIMIT(24),
        .CH_W         (CH_W)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_limit(cfg_limit),
        .cfg_phase(cfg_phase),
        .en_out   (en_out),
        .count    (count),
        .aligned  (aligned),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [WIDTH-1:0] cnt_of(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    task automatic cfg_write(input int ch, input int lim, input int ph);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_limit = WIDTH'(lim);
        cfg_phase = WIDTH'(ph);
        step();
        cfg_we    = 1'b0;
    endtask

    initial begin
        int pulses, first, last, al_cnt;

        reset_n = 1'b0; en = 1'b0; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0; cfg_phase = '0;
        #12;
        check("rst_count",   count, 0);
        check("rst_aligned", aligned, 1);
        check("rst_enout_en0", en_out, 4'h0);
        check("rst_cfg_err", cfg_err, 0);
        en = 1'b1;
        #1;
        check("rst_enout_en1", en_out, 4'hF);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("rst_sync_noeffect", count, 0);

        // Default divide-by-25 free run.
        reset_n = 1'b1;
        #1;
        check("c0_enout", en_out, 4'hF);
        check("c0_aligned", aligned, 1);
        pulses = 0; last = 0; al_cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (i == 24) check("c24_cnt0", cnt_of(0), 24);
            if (en_out[0]) begin pulses++; last = i; end
            if (aligned) al_cnt++;
        end
        check("def_pulses", pulses, 2);
        check("def_last_pulse", last, 50);
        check("def_aligned_cnt", al_cnt, 2);

        // ch1 limit=9 phase=3, written through together with sync.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_limit = 5'd9; cfg_phase = 5'd3; sync = 1'b1;
        step();
        cfg_we = 1'b0; sync = 1'b0;
        #1;
        check("ch1_sync_enout", en_out, 4'b1101);
        pulses = 0; first = -1;
        al_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (en_out[1]) begin pulses++; if (first < 0) first = i; end
            if (en_out[0]) al_cnt++;
        end
        check("ch1_pulses", pulses, 3);
        check("ch1_first", first, 3);
        check("ch0_unaffected", al_cnt, 1);
        check("ch1_cnt_30", cnt_of(1), 0);

        // ch0 limit=4 written at cnt=10: current 25-cycle period completes first.
        for (int i = 0; i < 5; i++) step();
        check("ch0_cnt10", cnt_of(0), 10);
        cfg_write(0, 4, 0);
        pulses = 0; first = -1; last = 0;
        for (int j = 1; j <= 24; j++) begin
            step();
            if (j == 13) check("ch0_reach24", cnt_of(0), 24);
            if (en_out[0]) begin pulses++; if (first < 0) first = j; last = j; end
        end
        check("ch0_new_pulses", pulses, 3);
        check("ch0_new_first", first, 14);
        check("ch0_new_last", last, 24);

        // 1-of-3 enable duty on ch3 (default limit): 75-clock spacing.
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("duty_sync_cnt3", cnt_of(3), 0);
        pulses = 0; first = -1; last = 0;
        for (int c = 0; c <= 150; c++) begin
            en = (c % 3 == 0);
            #1;
            if (en_out[3]) begin pulses++; if (first < 0) first = c; last = c; end
            step();
        end
        check("duty_pulses", pulses, 3);
        check("duty_first", first, 0);
        check("duty_last", last, 150);
        check("duty_cnt3", cnt_of(3), 1);

        // Pending configs on ch2/ch3 promoted by a mid-period sync.
        en = 1'b1;
        cfg_write(2, 7, 2);
        cfg_write(3, 10, 5);
        for (int i = 0; i < 13; i++) step();
        check("pre_sync_cnt3", cnt_of(3), 16);
        sync = 1'b1;
        step();
        sync = 1'b0;
        #1;
        check("sync_count", count, 0);
        check("sync_aligned", aligned, 1);
        check("sync_enout", en_out, 4'b0001);
        step(); step();
        check("ch2_phase2", en_out[2], 1);
        step(); step(); step();
        check("ch3_phase5", en_out[3], 1);
        check("ch2_not_pulse", en_out[2], 0);
        for (int i = 0; i < 5; i++) step();
        check("ch2_wrap_cnt", cnt_of(2), 2);
        check("ch2_limit7", en_out[2], 1);

        // Rejected write: phase > limit.
        en = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("err_idle", cfg_err, 0);
        cfg_write(0, 5, 7);
        check("err_pulse", cfg_err, 1);
        step();
        check("err_clear", cfg_err, 0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("err_ch0_cnt", cnt_of(0), 0);
        check("err_ch0_enout", en_out[0], 1);

        // Asynchronous reset mid-count, no clock edge required.
        for (int i = 0; i < 3; i++) step();
        check("pre_rst_ch3", cnt_of(3) != 0, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_aligned", aligned, 1);
        check("async_rst_enout", en_out, 4'hF);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("post_rst_ch1_default", cnt_of(1), 10);
        check("post_rst_ch1_phase", en_out[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gen_enable_multi.md
# gen_enable_multi

Parametrised multi-channel clock-enable generator for the photonic-switch timing path. Each channel has an up-counter with its own divide ratio and phase offset, and emits a one-cycle enable pulse once per period. Divide ratio and phase are runtime-programmable through a shadowed configuration port. A common synchronous `sync` realigns every channel at once, so derived enables stay phase-locked to each other without resetting the block.

## Interface
- `WIDTH`, 5: counter, limit and phase width in bits.
- `CHANNELS`, 4: number of independent enable channels (≥1).
- `DEFAULT_LIMIT`, 24: reset terminal count for every channel, giving divide-by-(DEFAULT_LIMIT+1) (25 → 8 MHz from 200 MHz).
- `CH_W`, $clog2(CHANNELS) (min 1): width of `cfg_ch`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global count enable; counters advance only when high.
- `sync`  in  1  synchronous realign: all counters to 0 and pending config applied.
- `cfg_we`  in  1  config write strobe.
- `cfg_ch`  in  CH_W  target channel of the write.
- `cfg_limit`  in  WIDTH  new terminal count; the period is cfg_limit+1 enabled cycles.
- `cfg_phase`  in  WIDTH  count value at which the channel pulses.
- `en_out`  out  CHANNELS  per-channel enable pulses.
- `count`  out  CHANNELS*WIDTH  live counter values; channel i occupies bits [i*WIDTH +: WIDTH].
- `aligned`  out  1  high when every channel counter is 0.
- `cfg_err`  out  1  one-cycle pulse on a rejected write.

## Operation
- Per-channel state:
  - `cnt`.
  - Active `limit` and `phase`.
  - Pending `p_limit` and `p_phase`.
- Counting, when `en`=1 and `sync`=0:
  - If `cnt` == active `limit`, `cnt` → 0 (wrap) and pending → active.
  - Otherwise `cnt` increments by 1.
  - When `en`=0, `cnt` holds.
- `en_out[i]` = `en` & (`cnt_i` == `phase_i`). This is combinational from registered state, so exactly one pulse occurs per period of enabled cycles.
- `sync`=1:
  - All `cnt` → 0 regardless of `en`.
  - Pending → active on every channel.
  - `sync` takes priority over counting.
- Config write, `cfg_we`=1:
  - Accepted when `cfg_phase` ≤ `cfg_limit` and `cfg_ch` < CHANNELS. The values go into the pending registers of that channel only; active values are untouched until that channel's next wrap or `sync`.
  - A write in the same cycle as that channel's wrap or `sync` is applied directly to active (write-through).
- Rejected write: `cfg_phase` > `cfg_limit`, or `cfg_ch` ≥ CHANNELS. Pending is unchanged, and `cfg_err` goes high for the next cycle only.
- `cfg_limit`=0: counter stays at 0 and `en_out[i]` = `en` (divide-by-1).
- A counter never exceeds its active limit, because the limit only changes when `cnt` becomes 0.
- `aligned` = AND over channels of (`cnt_i`==0), combinational, independent of `en`.

## Timing
- Reset (`reset_n`=0, asynchronous; held state persists until deassertion):
  - All `cnt`=0.
  - Active and pending limit = DEFAULT_LIMIT; active and pending phase = 0.
  - `cfg_err`=0.
- Outputs while in reset:
  - `en_out` = {CHANNELS{`en`}}, because phase 0 matches `cnt` 0.
  - `aligned`=1.
  - `count`=0.
- Counter update latency is 1 cycle from the qualifying `en`.
- `en_out` has 0-cycle latency from `en`.
- Config latency:
  - A write at cycle t is in pending at t+1.
  - It becomes active at the first wrap or `sync` edge at or after t. A write during that edge is write-through.
- `cfg_err` is registered and asserts in cycle t+1 for a bad write at t.
- `sync` during reset has no effect. Reset mid-period discards the period, and the first pulse follows deassertion at `cnt`=0.

## Test plan
- Reset then `en`=1 constant, defaults → `en_out[0..3]` high at cycles 0, 25, 50; `count` ramps 0…24→0; `aligned`=1 at those cycles only.
- Write ch1 limit=9, phase=3 while ch1 `cnt`=0 via `sync` → `en_out[1]` pulses when `cnt`=3, every 10 cycles; other channels unaffected.
- Write ch0 limit=4 at `cnt`=10 → current period still ends at 24 (25 cycles); then period 5, pulses at `cnt`=0.
- Toggle `en` 1-of-3 duty → counters advance only on `en`=1 cycles; pulse spacing is 75 clocks at default limit.
- Offset channels (ch2 limit=7, free-running) then pulse `sync` mid-period → all `count`=0 next cycle, `aligned`=1, pending values active.
- Write phase=7, limit=5 → `cfg_err`=1 for one cycle, behaviour unchanged. Assert `reset_n`=0 mid-count → `count`=0 immediately, without a clock edge.
